// File: rtl/hls_module_perf_monitor_if.sv
// ---------------------------------------------------------------------------
// hls_module_perf_monitor_if
// Bundle of the per-channel HLS block-level handshake signals
// (ap_ctrl_hs / ap_ctrl_chain) observed by hls_module_perf_monitor.
//   ap_start    : per-channel module start
//   ap_ready    : per-channel input-accept pulse
//   ap_done     : per-channel completion
//   ap_continue : per-channel continue (tie high for ap_ctrl_hs modules)
// Modports:
//   master : the side producing the handshake (design under observation / bench)
//   slave  : the monitor, which only observes
// ---------------------------------------------------------------------------
interface hls_module_perf_monitor_if #(
    parameter int N_CH = 2
);
    logic [N_CH-1:0] ap_start;
    logic [N_CH-1:0] ap_ready;
    logic [N_CH-1:0] ap_done;
    logic [N_CH-1:0] ap_continue;

    modport master (
        output ap_start,
        output ap_ready,
        output ap_done,
        output ap_continue
    );

    modport slave (
        input ap_start,
        input ap_ready,
        input ap_done,
        input ap_continue
    );
endinterface

// File: rtl/hls_module_perf_monitor.sv
// ---------------------------------------------------------------------------
// hls_module_perf_monitor
// N-channel monitor for HLS ap_ctrl_hs / ap_ctrl_chain handshakes. Each
// channel tracks one module's start/done/continue sequence and accumulates
// transaction, cycle and latency statistics. Statistics can be cleared,
// frozen at end of run, and read back through a registered select port.
//   i_clock        : system clock, rising edge
//   i_reset        : synchronous active-high reset
//   i_finish       : end of run; first high cycle sets o_frozen
//   i_clear        : synchronous statistics clear (ignored while frozen)
//   ap_if          : per-channel handshake bundle (slave modport)
//   i_rd_sel       : readback channel select
//   i_rd_field     : readback statistic select
//                    0 done 1 ready 2 busy 3 stall 4 last 5 min 6 max
//                    7 {proto_err, overflow, state[1:0]}
//   o_rd_data      : registered readback value (1-cycle latency)
//   o_frozen       : sticky statistics-frozen flag
//   o_any_overflow : OR of per-channel counter overflow flags
// ---------------------------------------------------------------------------
module hls_module_perf_monitor #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 32,
    parameter int LAT_W = 16,
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_finish,
    input  logic                       i_clear,
    hls_module_perf_monitor_if.slave   ap_if,
    input  logic [SEL_W-1:0]           i_rd_sel,
    input  logic [2:0]                 i_rd_field,
    output logic [CNT_W-1:0]           o_rd_data,
    output logic                       o_frozen,
    output logic                       o_any_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_CONT = 2'd2
    } state_e;

    state_e             r_state   [N_CH];
    logic [LAT_W-1:0]   r_lat_cnt [N_CH];
    logic [CNT_W-1:0]   r_done    [N_CH];
    logic [CNT_W-1:0]   r_ready   [N_CH];
    logic [CNT_W-1:0]   r_busy    [N_CH];
    logic [CNT_W-1:0]   r_stall   [N_CH];
    logic [LAT_W-1:0]   r_last    [N_CH];
    logic [LAT_W-1:0]   r_min     [N_CH];
    logic [LAT_W-1:0]   r_max     [N_CH];
    logic [N_CH-1:0]    r_ovf;
    logic [N_CH-1:0]    r_perr;
    logic               r_frozen;
    logic [CNT_W-1:0]   r_rd_data;

    state_e             w_nstate  [N_CH];
    logic [LAT_W-1:0]   w_nlat    [N_CH];
    logic [LAT_W-1:0]   w_lat     [N_CH];
    logic [N_CH-1:0]    w_rec;
    logic [N_CH-1:0]    w_busy;
    logic [N_CH-1:0]    w_stall;
    logic [N_CH-1:0]    w_perr;
    logic [N_CH-1:0]    w_ovf_ev;
    logic [CNT_W-1:0]   w_rd_next;

    function automatic logic [LAT_W-1:0] lat_inc(input logic [LAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Per-channel next state and event decode
    always_comb begin
        for (int unsigned c = 0; c < N_CH; c++) begin
            w_nstate[c] = r_state[c];
            w_nlat[c]   = r_lat_cnt[c];
            w_lat[c]    = '0;
            w_rec[c]    = 1'b0;
            w_busy[c]   = 1'b0;
            w_stall[c]  = 1'b0;
            w_perr[c]   = 1'b0;
            case (r_state[c])
                ST_IDLE: begin
                    if (ap_if.ap_start[c]) begin
                        w_busy[c] = 1'b1;
                        if (ap_if.ap_done[c]) begin
                            w_rec[c]    = 1'b1;
                            w_lat[c]    = LAT_W'(1);
                            w_nstate[c] = ap_if.ap_continue[c] ? ST_IDLE : ST_WAIT_CONT;
                        end else begin
                            w_nstate[c] = ST_RUN;
                            w_nlat[c]   = LAT_W'(1);
                        end
                    end else if (ap_if.ap_done[c]) begin
                        w_perr[c] = 1'b1;
                    end
                end
                ST_RUN: begin
                    w_busy[c] = 1'b1;
                    w_nlat[c] = lat_inc(r_lat_cnt[c]);
                    if (ap_if.ap_done[c]) begin
                        w_rec[c]    = 1'b1;
                        w_lat[c]    = lat_inc(r_lat_cnt[c]);
                        w_nstate[c] = ap_if.ap_continue[c] ? ST_IDLE : ST_WAIT_CONT;
                    end
                end
                ST_WAIT_CONT: begin
                    w_stall[c] = 1'b1;
                    if (ap_if.ap_continue[c]) begin
                        w_nstate[c] = ST_IDLE;
                    end
                end
                default: w_nstate[c] = ST_IDLE;
            endcase
            // An increment attempted on an already saturated counter flags overflow
            w_ovf_ev[c] = (w_rec[c]            && (r_done[c]  == '1)) ||
                          (ap_if.ap_ready[c]   && (r_ready[c] == '1)) ||
                          (w_busy[c]           && (r_busy[c]  == '1)) ||
                          (w_stall[c]          && (r_stall[c] == '1));
        end
    end

    // FSMs always track; statistics only move while not frozen, and a clear
    // in the same cycle as an event takes priority over it.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_frozen <= 1'b0;
            r_ovf    <= '0;
            r_perr   <= '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                r_state[c]   <= ST_IDLE;
                r_lat_cnt[c] <= '0;
                r_done[c]    <= '0;
                r_ready[c]   <= '0;
                r_busy[c]    <= '0;
                r_stall[c]   <= '0;
                r_last[c]    <= '0;
                r_min[c]     <= '1;
                r_max[c]     <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                r_state[c]   <= w_nstate[c];
                r_lat_cnt[c] <= w_nlat[c];
            end
            if (!r_frozen) begin
                if (i_finish) begin
                    r_frozen <= 1'b1;
                end
                if (i_clear) begin
                    r_ovf  <= '0;
                    r_perr <= '0;
                    for (int unsigned c = 0; c < N_CH; c++) begin
                        r_done[c]  <= '0;
                        r_ready[c] <= '0;
                        r_busy[c]  <= '0;
                        r_stall[c] <= '0;
                        r_last[c]  <= '0;
                        r_min[c]   <= '1;
                        r_max[c]   <= '0;
                    end
                end else begin
                    r_ovf  <= r_ovf | w_ovf_ev;
                    r_perr <= r_perr | w_perr;
                    for (int unsigned c = 0; c < N_CH; c++) begin
                        if (w_rec[c]) begin
                            r_done[c] <= cnt_inc(r_done[c]);
                            r_last[c] <= w_lat[c];
                            if (w_lat[c] < r_min[c]) r_min[c] <= w_lat[c];
                            if (w_lat[c] > r_max[c]) r_max[c] <= w_lat[c];
                        end
                        if (ap_if.ap_ready[c]) r_ready[c] <= cnt_inc(r_ready[c]);
                        if (w_busy[c])         r_busy[c]  <= cnt_inc(r_busy[c]);
                        if (w_stall[c])        r_stall[c] <= cnt_inc(r_stall[c]);
                    end
                end
            end
        end
    end

    always_comb begin
        w_rd_next = '0;
        if (int'(i_rd_sel) < N_CH) begin
            case (i_rd_field)
                3'd0:    w_rd_next = r_done[i_rd_sel];
                3'd1:    w_rd_next = r_ready[i_rd_sel];
                3'd2:    w_rd_next = r_busy[i_rd_sel];
                3'd3:    w_rd_next = r_stall[i_rd_sel];
                3'd4:    w_rd_next = CNT_W'(r_last[i_rd_sel]);
                3'd5:    w_rd_next = CNT_W'(r_min[i_rd_sel]);
                3'd6:    w_rd_next = CNT_W'(r_max[i_rd_sel]);
                default: w_rd_next = CNT_W'({r_perr[i_rd_sel], r_ovf[i_rd_sel], r_state[i_rd_sel]});
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_next;
        end
    end

    assign o_rd_data      = r_rd_data;
    assign o_frozen       = r_frozen;
    assign o_any_overflow = |r_ovf;

endmodule

// File: tb/tb_hls_module_perf_monitor.sv
// ---------------------------------------------------------------------------
// tb_hls_module_perf_monitor
// Bench for hls_module_perf_monitor. Two instances: a default one
// (N_CH=2, CNT_W=32, LAT_W=16) and a narrow one (N_CH=1, CNT_W=4, LAT_W=4)
// for saturation. The reference model works on transaction timestamps:
// a latency is (done cycle - start cycle + 1), clipped to the register range.
// ---------------------------------------------------------------------------
module tb_hls_module_perf_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr0, clr1, fin0, fin1;
    logic [0:0]  sel0, sel1;
    logic [2:0]  fld0, fld1;
    logic [31:0] rd0;
    logic [3:0]  rd1;
    logic        frz0, frz1, aovf0, aovf1;

    hls_module_perf_monitor_if #(.N_CH(2)) if0 ();
    hls_module_perf_monitor_if #(.N_CH(1)) if1 ();

    hls_module_perf_monitor #(.N_CH(2), .CNT_W(32), .LAT_W(16)) dut0 (
        .i_clock(clk), .i_reset(rst), .i_finish(fin0), .i_clear(clr0),
        .ap_if(if0), .i_rd_sel(sel0), .i_rd_field(fld0), .o_rd_data(rd0),
        .o_frozen(frz0), .o_any_overflow(aovf0)
    );

    hls_module_perf_monitor #(.N_CH(1), .CNT_W(4), .LAT_W(4)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_finish(fin1), .i_clear(clr1),
        .ap_if(if1), .i_rd_sel(sel1), .i_rd_field(fld1), .o_rd_data(rd1),
        .o_frozen(frz1), .o_any_overflow(aovf1)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: index 0,1 = dut0 channels, 2 = dut1 channel 0
    longint unsigned m_done[3], m_ready[3], m_busy[3], m_stall[3];
    longint unsigned m_last[3], m_min[3], m_max[3];
    longint unsigned m_cmax[3], m_lmax[3];
    longint          m_t0[3];
    int              m_phase[3];     // 0 idle, 1 running, 2 waiting for continue
    bit              m_ovf[3], m_perr[3];
    bit              m_frozen[2];
    longint          cyc = 0;
    longint unsigned exp_rd0, exp_rd1;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_done[k] = 0; m_ready[k] = 0; m_busy[k] = 0; m_stall[k] = 0;
            m_last[k] = 0; m_max[k] = 0; m_min[k] = m_lmax[k];
            m_ovf[k] = 0; m_perr[k] = 0; m_phase[k] = 0; m_t0[k] = 0;
        end
        m_frozen[0] = 0;
        m_frozen[1] = 0;
    endtask

    function automatic longint unsigned mfield(int k, logic [2:0] f);
        case (f)
            3'd0: return m_done[k];
            3'd1: return m_ready[k];
            3'd2: return m_busy[k];
            3'd3: return m_stall[k];
            3'd4: return m_last[k];
            3'd5: return m_min[k];
            3'd6: return m_max[k];
            default: return longint'(m_perr[k]) * 8 + longint'(m_ovf[k]) * 4 + longint'(m_phase[k]);
        endcase
    endfunction

    task automatic model_step(int k, bit st, bit rdy, bit dn, bit ct, bit clr);
        bit rec, busy, stall, perr;
        longint unsigned lat;
        int d;
        rec = 0; busy = 0; stall = 0; perr = 0; lat = 0;
        d = (k < 2) ? 0 : 1;
        case (m_phase[k])
            0: begin
                if (st) begin
                    busy = 1;
                    m_t0[k] = cyc;
                    if (dn) begin
                        rec = 1; lat = 1;
                        m_phase[k] = ct ? 0 : 2;
                    end else begin
                        m_phase[k] = 1;
                    end
                end else if (dn) begin
                    perr = 1;
                end
            end
            1: begin
                busy = 1;
                if (dn) begin
                    rec = 1;
                    lat = longint'(cyc - m_t0[k] + 1);
                    if (lat > m_lmax[k]) lat = m_lmax[k];
                    m_phase[k] = ct ? 0 : 2;
                end
            end
            default: begin
                stall = 1;
                if (ct) m_phase[k] = 0;
            end
        endcase
        if (!m_frozen[d]) begin
            if (clr) begin
                m_done[k] = 0; m_ready[k] = 0; m_busy[k] = 0; m_stall[k] = 0;
                m_last[k] = 0; m_max[k] = 0; m_min[k] = m_lmax[k];
                m_ovf[k] = 0; m_perr[k] = 0;
            end else begin
                if (rec) begin
                    if (m_done[k] == m_cmax[k]) m_ovf[k] = 1; else m_done[k]++;
                    m_last[k] = lat;
                    if (lat < m_min[k]) m_min[k] = lat;
                    if (lat > m_max[k]) m_max[k] = lat;
                end
                if (rdy)   begin if (m_ready[k] == m_cmax[k]) m_ovf[k] = 1; else m_ready[k]++; end
                if (busy)  begin if (m_busy[k]  == m_cmax[k]) m_ovf[k] = 1; else m_busy[k]++;  end
                if (stall) begin if (m_stall[k] == m_cmax[k]) m_ovf[k] = 1; else m_stall[k]++; end
                if (perr) m_perr[k] = 1;
            end
        end
    endtask

    // One clock: compute expected readback from pre-edge state, advance model, clock DUTs
    task automatic cycle();
        exp_rd0 = mfield(int'(sel0), fld0);
        exp_rd1 = (sel1 == 1'b0) ? mfield(2, fld1) : 0;
        if (rst) begin
            @(posedge clk); #1;
            model_reset();
            exp_rd0 = 0;
            exp_rd1 = 0;
        end else begin
            for (int k = 0; k < 2; k++)
                model_step(k, if0.ap_start[k], if0.ap_ready[k], if0.ap_done[k], if0.ap_continue[k], clr0);
            model_step(2, if1.ap_start[0], if1.ap_ready[0], if1.ap_done[0], if1.ap_continue[0], clr1);
            if (fin0) m_frozen[0] = 1;
            if (fin1) m_frozen[1] = 1;
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic set_in(int d, int ch, bit st, bit rdy, bit dn, bit ct);
        if (d == 0) begin
            if0.ap_start[ch] = st; if0.ap_ready[ch] = rdy;
            if0.ap_done[ch] = dn;  if0.ap_continue[ch] = ct;
        end else begin
            if1.ap_start[0] = st; if1.ap_ready[0] = rdy;
            if1.ap_done[0] = dn;  if1.ap_continue[0] = ct;
        end
    endtask

    task automatic read_field(int d, int ch, int f);
        if (d == 0) begin sel0 = 1'(ch); fld0 = 3'(f); end
        else        begin sel1 = 1'(ch); fld1 = 3'(f); end
        cycle();
    endtask

    // One transaction of latency lat (>=1), continue withheld for w wait cycles
    task automatic txn(int d, int ch, int lat, int w);
        bit ct;
        ct = (w == 0);
        set_in(d, ch, 1, 0, lat == 1, ct);
        cycle();
        set_in(d, ch, 0, 0, 0, ct);
        if (lat > 1) begin
            repeat (lat - 2) cycle();
            set_in(d, ch, 0, 0, 1, ct);
            cycle();
            set_in(d, ch, 0, 0, 0, ct);
        end
        if (w > 0) begin
            repeat (w - 1) cycle();
            set_in(d, ch, 0, 0, 0, 1);
            cycle();
        end
        set_in(d, ch, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        vectors++;
        if (frz0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_frozen: got %0b expected 0", frz0);
        end
        for (int f = 0; f < 8; f++) begin
            read_field(0, 0, f);
            vectors++;
            if (rd0 !== exp_rd0[31:0]) begin
                miscompares++;
                $display("FAIL reset_field%0d: got %0h expected %0h", f, rd0, exp_rd0);
            end
        end
    endtask

    task automatic test_single_txn();
        txn(0, 0, 5, 0);
        for (int f = 0; f < 8; f++) begin
            read_field(0, 0, f);
            vectors++;
            if (rd0 !== exp_rd0[31:0]) begin
                miscompares++;
                $display("FAIL single_txn_field%0d: got %0h expected %0h", f, rd0, exp_rd0);
            end
        end
    endtask

    task automatic test_latencies();
        txn(0, 1, 3, 0);
        txn(0, 1, 7, 0);
        txn(0, 1, 1, 0);
        for (int f = 0; f < 8; f++) begin
            read_field(0, 1, f);
            vectors++;
            if (rd0 !== exp_rd0[31:0]) begin
                miscompares++;
                $display("FAIL latencies_field%0d: got %0h expected %0h", f, rd0, exp_rd0);
            end
        end
    endtask

    // Status watched every cycle across RUN -> WAIT_CONT -> IDLE
    task automatic test_stall();
        bit tbl_st[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
        bit tbl_dn[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        bit tbl_ct[8] = '{1, 0, 0, 0, 0, 1, 1, 1};
        sel0 = 1'b0;
        fld0 = 3'd7;
        for (int i = 0; i < 8; i++) begin
            set_in(0, 0, tbl_st[i], 0, tbl_dn[i], tbl_ct[i]);
            cycle();
            vectors++;
            if (rd0 !== exp_rd0[31:0]) begin
                miscompares++;
                $display("FAIL stall_status_step%0d: got %0h expected %0h", i, rd0, exp_rd0);
            end
        end
        set_in(0, 0, 0, 0, 0, 1);
        for (int f = 0; f < 4; f++) begin
            read_field(0, 0, f);
            vectors++;
            if (rd0 !== exp_rd0[31:0]) begin
                miscompares++;
                $display("FAIL stall_field%0d: got %0h expected %0h", f, rd0, exp_rd0);
            end
        end
    endtask

    // Random concurrent traffic on every channel, all outputs checked each cycle
    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            for (int ch = 0; ch < 2; ch++)
                set_in(0, ch, $urandom_range(1, 0) == 1, $urandom_range(2, 0) == 0,
                       $urandom_range(3, 0) == 0, $urandom_range(3, 0) != 0);
            set_in(1, 0, $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 0,
                   $urandom_range(3, 0) == 0, $urandom_range(3, 0) != 0);
            clr0 = ($urandom_range(99, 0) == 0);
            clr1 = ($urandom_range(49, 0) == 0);
            sel0 = 1'($urandom_range(1, 0));
            fld0 = 3'($urandom_range(7, 0));
            sel1 = 1'($urandom_range(1, 0));
            fld1 = 3'($urandom_range(7, 0));
            cycle();
            vectors++;
            if (rd0 !== exp_rd0[31:0]) begin
                miscompares++;
                $display("FAIL rand_rd0 cyc %0d: got %0h expected %0h", i, rd0, exp_rd0);
            end
            vectors++;
            if (rd1 !== exp_rd1[3:0]) begin
                miscompares++;
                $display("FAIL rand_rd1 cyc %0d: got %0h expected %0h", i, rd1, exp_rd1);
            end
            vectors++;
            if (aovf0 !== (m_ovf[0] | m_ovf[1]) || aovf1 !== m_ovf[2]) begin
                miscompares++;
                $display("FAIL rand_any_overflow cyc %0d: got %0b/%0b expected %0b/%0b",
                         i, aovf0, aovf1, m_ovf[0] | m_ovf[1], m_ovf[2]);
            end
        end
        clr0 = 0;
        clr1 = 0;
        for (int ch = 0; ch < 2; ch++) set_in(0, ch, 0, 0, 0, 1);
        set_in(1, 0, 0, 0, 0, 1);
    endtask

    task automatic test_saturation();
        rst = 1;
        cycle();
        rst = 0;
        txn(1, 0, 20, 0);
        read_field(1, 0, 4);
        vectors++;
        if (rd1 !== exp_rd1[3:0]) begin
            miscompares++;
            $display("FAIL sat_last_lat: got %0h expected %0h", rd1, exp_rd1);
        end
        set_in(1, 0, 0, 1, 0, 1);
        repeat (16) cycle();
        set_in(1, 0, 0, 0, 0, 1);
        for (int f = 0; f < 8; f++) begin
            read_field(1, 0, f);
            vectors++;
            if (rd1 !== exp_rd1[3:0]) begin
                miscompares++;
                $display("FAIL sat_field%0d: got %0h expected %0h", f, rd1, exp_rd1);
            end
        end
        vectors++;
        if (aovf1 !== m_ovf[2]) begin
            miscompares++;
            $display("FAIL sat_any_overflow: got %0b expected %0b", aovf1, m_ovf[2]);
        end
        clr1 = 1;
        cycle();
        clr1 = 0;
        vectors++;
        if (aovf1 !== m_ovf[2]) begin
            miscompares++;
            $display("FAIL clear_any_overflow: got %0b expected %0b", aovf1, m_ovf[2]);
        end
        for (int f = 0; f < 8; f++) begin
            read_field(1, 0, f);
            vectors++;
            if (rd1 !== exp_rd1[3:0]) begin
                miscompares++;
                $display("FAIL clear_field%0d: got %0h expected %0h", f, rd1, exp_rd1);
            end
        end
        read_field(1, 1, 1);
        vectors++;
        if (rd1 !== 4'h0) begin
            miscompares++;
            $display("FAIL sel_out_of_range: got %0h expected 0", rd1);
        end
    endtask

    task automatic test_finish();
        fin0 = 1;
        cycle();
        fin0 = 0;
        vectors++;
        if (frz0 !== m_frozen[0]) begin
            miscompares++;
            $display("FAIL finish_frozen: got %0b expected %0b", frz0, m_frozen[0]);
        end
        txn(0, 0, 3, 2);
        clr0 = 1;
        cycle();
        clr0 = 0;
        for (int f = 0; f < 8; f++) begin
            read_field(0, 0, f);
            vectors++;
            if (rd0 !== exp_rd0[31:0]) begin
                miscompares++;
                $display("FAIL frozen_field%0d: got %0h expected %0h", f, rd0, exp_rd0);
            end
        end
        // Reset in the middle of a transaction
        set_in(0, 0, 1, 0, 0, 1);
        cycle();
        set_in(0, 0, 0, 0, 0, 1);
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        vectors++;
        if (frz0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_unfreeze: got %0b expected 0", frz0);
        end
        for (int f = 0; f < 8; f++) begin
            read_field(0, 0, f);
            vectors++;
            if (rd0 !== exp_rd0[31:0]) begin
                miscompares++;
                $display("FAIL midrun_reset_field%0d: got %0h expected %0h", f, rd0, exp_rd0);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        m_cmax = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
        m_lmax = '{64'd65535, 64'd65535, 64'd15};
        model_reset();
        rst = 1; clr0 = 0; clr1 = 0; fin0 = 0; fin1 = 0;
        sel0 = 0; sel1 = 0; fld0 = 0; fld1 = 0;
        if0.ap_start = '0; if0.ap_ready = '0; if0.ap_done = '0; if0.ap_continue = '1;
        if1.ap_start = '0; if1.ap_ready = '0; if1.ap_done = '0; if1.ap_continue = '1;
        @(posedge clk); #1;
        test_reset();
        test_single_txn();
        test_latencies();
        test_stall();
        test_back_to_back();
        test_saturation();
        test_finish();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
